bsg_mem_1rw_sync_rv_adapter: RTL

Wraps a single-port synchronous mask-write memory behind ready/valid request and response streams. Sits directly upstream of `bsg_mem_1rw_sync_mask_write_bit_banked` (or the unbanked equivalent):
- Drives its `v_i`/`w_i`/`addr_i`/`data_i`/`w_mask_i`.
- Consumes its `data_o` exactly one cycle after a read issues.
- Buffers read data so that a consumer applying backpressure never loses a response.
- Credit-limits issue so the memory's 1-cycle read latency supports one request per cycle.

---
 rtl/bsg_mem_rv_adapter_pkg.sv | 14 +
 rtl/bsg_mem_rv_resp_fifo.sv | 50 +++++
 rtl/bsg_mem_1rw_sync_rv_adapter.sv | 81 ++++++++
 3 files changed

// File: rtl/bsg_mem_rv_adapter_pkg.sv
// bsg_mem_rv_adapter_pkg: shared constants and request struct macro for the rv memory adapter
`ifndef BSG_MEM_RV_ADAPTER_PKG_SV
`define BSG_MEM_RV_ADAPTER_PKG_SV
package bsg_mem_rv_adapter_pkg;
  localparam int bsg_mem_rv_adapter_min_resp_els_gp = 2;
endpackage
`define BSG_MEM_RV_ADAPTER_DECLARE_REQ_S(width_mp, addr_width_mp) \
  typedef struct packed { \
    logic w; \
    logic [addr_width_mp-1:0] addr; \
    logic [width_mp-1:0] data; \
    logic [width_mp-1:0] w_mask; \
  } bsg_mem_rv_adapter_req_s
`endif

// File: rtl/bsg_mem_rv_resp_fifo.sv
// bsg_mem_rv_resp_fifo: flop-based circular response buffer with head-visible output
module bsg_mem_rv_resp_fifo #(
  parameter int width_p = 32,
  parameter int els_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_v_i,
  input  logic [width_p-1:0] push_data_i,
  input  logic               pop_yumi_i,
  output logic               head_v_o,
  output logic [width_p-1:0] head_data_o
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);
  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] mem_d [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  assign head_v_o = cnt_q != '0;
  assign head_data_o = mem_q[rptr_q];
  // next pointers, occupancy and storage contents
  always_comb begin
    mem_d = mem_q;
    if (push_v_i) mem_d[wptr_q] = push_data_i;
    wptr_d = reset_i ? '0 : push_v_i ? ((wptr_q == last_lp) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d = reset_i ? '0 : pop_yumi_i ? ((rptr_q == last_lp) ? '0 : rptr_q + 1'b1) : rptr_q;
    cnt_d = reset_i ? '0 : cnt_q + cnt_w_lp'(push_v_i) - cnt_w_lp'(pop_yumi_i);
  end
  // pointer and occupancy state
  always_ff @(posedge clk_i) begin
    wptr_q <= wptr_d;
    rptr_q <= rptr_d;
    cnt_q <= cnt_d;
  end
  // storage has no reset; occupancy alone decides validity
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end
`ifndef SYNTHESIS
  // overflow and underflow are structural bugs in the caller
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(push_v_i && !pop_yumi_i && cnt_q == cnt_w_lp'(els_p))) else $error("resp fifo push when full");
      assert (!(pop_yumi_i && cnt_q == '0)) else $error("resp fifo pop when empty");
    end
  end
`endif
endmodule

// File: rtl/bsg_mem_1rw_sync_rv_adapter.sv
// bsg_mem_1rw_sync_rv_adapter: ready/valid front end for a 1rw sync mask-write memory; BSG_MEM_RV_ADAPTER_WRITE_ACK_EN makes writes return a zero ack
module bsg_mem_1rw_sync_rv_adapter
  import bsg_mem_rv_adapter_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p = 16,
  parameter int resp_els_p = 2,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);
  `BSG_MEM_RV_ADAPTER_DECLARE_REQ_S(width_p, addr_width_lp);
  localparam int cnt_w_lp = $clog2(resp_els_p + 1);
`ifdef BSG_MEM_RV_ADAPTER_WRITE_ACK_EN
  localparam logic write_ack_lp = 1'b1;
`else
  localparam logic write_ack_lp = 1'b0;
`endif
  bsg_mem_rv_adapter_req_s req;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic pend_q, pend_d, pend_w_q, pend_w_d;
  logic issue_resp, head_v, push_v, pop_v;
  logic [width_p-1:0] head_data, resp_data;
  assign req = '{w: w_i, addr: addr_i, data: data_i, w_mask: w_mask_i};
  assign ready_o = ~reset_i & (count_q < cnt_w_lp'(resp_els_p));
  assign mem_v_o = v_i & ready_o;
  assign mem_w_o = req.w;
  assign mem_addr_o = req.addr;
  assign mem_data_o = req.data;
  assign mem_w_mask_o = req.w_mask;
  // credits are taken at issue and returned on yumi; the bypass serves an empty buffer
  always_comb begin
    issue_resp = mem_v_o & (~w_i | write_ack_lp);
    resp_data = pend_w_q ? '0 : mem_data_i;
    v_o = head_v | pend_q;
    data_o = head_v ? head_data : resp_data;
    push_v = pend_q & (head_v | ~yumi_i);
    pop_v = yumi_i & head_v;
    count_d = reset_i ? '0 : count_q + cnt_w_lp'(issue_resp) - cnt_w_lp'(yumi_i);
    pend_d = ~reset_i & issue_resp;
    pend_w_d = w_i;
  end
  // credit count and one-deep in-flight tracking
  always_ff @(posedge clk_i) begin
    count_q <= count_d;
    pend_q <= pend_d;
    pend_w_q <= pend_w_d;
  end
  bsg_mem_rv_resp_fifo #(.width_p(width_p), .els_p(resp_els_p)) fifo (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .push_v_i(push_v),
    .push_data_i(resp_data),
    .pop_yumi_i(pop_v),
    .head_v_o(head_v),
    .head_data_o(head_data)
  );
`ifndef SYNTHESIS
  // configuration and handshake sanity
  always_ff @(posedge clk_i) begin
    assert (resp_els_p >= bsg_mem_rv_adapter_min_resp_els_gp) else $error("resp_els_p below minimum");
    if (!reset_i) assert (!(yumi_i && !v_o)) else $error("yumi_i without v_o");
  end
`endif
endmodule
